// File: rtl/sumador_bit.sv
// One-bit full adder cell; the ripple-carry stage of sumador_completo.
module sumador_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sumador_completo.sv
// WIDTH-bit ripple-carry adder with a combinational result and a registered copy.
module sumador_completo #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] St,
  output logic             Cout,
  output logic [WIDTH-1:0] St_r,
  output logic             Cout_r
);

  // Per-stage carry signals keep the chain as separate nets rather than one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci_w;
    logic co_w;

    if (i == 0) begin : g_first
      assign ci_w = Cin;
    end else begin : g_rest
      assign ci_w = g_bit[i-1].co_w;
    end

    sumador_bit u_bit (
      .a  (A[i]),
      .b  (B[i]),
      .ci (ci_w),
      .s  (St[i]),
      .co (co_w)
    );
  end

  assign Cout = g_bit[WIDTH-1].co_w;

  // Output register; reset only clears the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      St_r   <= '0;
      Cout_r <= 1'b0;
    end else begin
      St_r   <= St;
      Cout_r <= Cout;
    end
  end

endmodule

// File: tb/tb_sumador_completo.sv
// Bench for sumador_completo at WIDTH=1 and WIDTH=4 against an arithmetic reference model.
module tb_sumador_completo;

  logic       clk;
  logic       rst;
  logic       cin1, a1, b1;
  logic       st1, cout1, st1_r, cout1_r;
  logic       cin4;
  logic [3:0] a4, b4;
  logic [3:0] st4, st4_r;
  logic       cout4, cout4_r;

  int unsigned n_cmp;
  int unsigned n_bad;

  sumador_completo #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .Cin    (cin1),
    .A      (a1),
    .B      (b1),
    .St     (st1),
    .Cout   (cout1),
    .St_r   (st1_r),
    .Cout_r (cout1_r)
  );

  sumador_completo #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .Cin    (cin4),
    .A      (a4),
    .B      (b4),
    .St     (st4),
    .Cout   (cout4),
    .St_r   (st4_r),
    .Cout_r (cout4_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer sum of the operands; returns {carry, sum} at width+1 bits.
  function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    longint unsigned mask, tot;
    mask = (64'd1 << w) - 64'd1;
    tot  = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
    return 33'(tot);
  endfunction

  logic [32:0] m1, m4;
  logic [32:0] r1, r4;
  logic [2:0]  v;
  logic [1:0]  tab_st_cout [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Truth table {St, Cout} indexed by {Cin, A, B}.
    tab_st_cout[0] = 2'b00; tab_st_cout[1] = 2'b10;
    tab_st_cout[2] = 2'b10; tab_st_cout[3] = 2'b01;
    tab_st_cout[4] = 2'b10; tab_st_cout[5] = 2'b01;
    tab_st_cout[6] = 2'b01; tab_st_cout[7] = 2'b11;

    rst = 1'b1; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    cin4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_st1_r", 32'(st1_r), 32'd0);
    check("reset_cout1_r", 32'(cout1_r), 32'd0);
    check("reset_st4_r", 32'(st4_r), 32'd0);
    check("reset_cout4_r", 32'(cout4_r), 32'd0);

    // Exhaustive WIDTH=1, checked 10 time units after applying.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {cin1, a1, b1} = v;
      #10;
      check($sformatf("w1_st_%0d", i), 32'(st1), 32'(tab_st_cout[i][1]));
      check($sformatf("w1_cout_%0d", i), 32'(cout1), 32'(tab_st_cout[i][0]));
      check($sformatf("w1_st_r_%0d", i), 32'(st1_r), 32'(tab_st_cout[i][1]));
      check($sformatf("w1_cout_r_%0d", i), 32'(cout1_r), 32'(tab_st_cout[i][0]));
    end

    // Registered path: holds old value until the edge, then loads.
    cin1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    #1;
    check("reg_hold_st_r", 32'(st1_r), 32'd1);
    check("reg_hold_cout_r", 32'(cout1_r), 32'd1);
    @(posedge clk); #1;
    check("reg_load_st_r", 32'(st1_r), 32'd0);
    check("reg_load_cout_r", 32'(cout1_r), 32'd1);

    // Mid-stream reset: registers clear, combinational outputs keep tracking.
    @(negedge clk);
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    check("rst_st_r", 32'(st1_r), 32'd0);
    check("rst_cout_r", 32'(cout1_r), 32'd0);
    check("rst_st_comb", 32'(st1), 32'd1);
    check("rst_cout_comb", 32'(cout1), 32'd1);

    // Reset release: first edge loads current sum.
    @(negedge clk);
    rst = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #1;
    check("rel_pre_cout_r", 32'(cout1_r), 32'd0);
    @(posedge clk); #1;
    check("rel_st_r", 32'(st1_r), 32'd0);
    check("rel_cout_r", 32'(cout1_r), 32'd1);

    // WIDTH=4 directed wrap-around and no-carry cases.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    #1;
    check("w4_wrap1_st", 32'(st4), 32'h0);
    check("w4_wrap1_cout", 32'(cout4), 32'd1);
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b1;
    #1;
    check("w4_wrap2_st", 32'(st4), 32'h0);
    check("w4_wrap2_cout", 32'(cout4), 32'd1);
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h2; cin4 = 1'b1;
    #1;
    check("w4_nc_st", 32'(st4), 32'h8);
    check("w4_nc_cout", 32'(cout4), 32'd0);
    @(posedge clk); #1;
    check("w4_nc_st_r", 32'(st4_r), 32'h8);
    check("w4_nc_cout_r", 32'(cout4_r), 32'd0);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 9) == 0);
      cin1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      cin4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      m1 = model(1, 32'(a1), 32'(b1), cin1);
      m4 = model(4, 32'(a4), 32'(b4), cin4);
      r1 = rst ? 33'd0 : m1;
      r4 = rst ? 33'd0 : m4;
      #1;
      check("rnd_w1_comb", 32'({cout1, st1}), 32'(m1[1:0]));
      check("rnd_w4_comb", 32'({cout4, st4}), 32'(m4[4:0]));
      @(posedge clk); #1;
      check("rnd_w1_reg", 32'({cout1_r, st1_r}), 32'(r1[1:0]));
      check("rnd_w4_reg", 32'({cout4_r, st4_r}), 32'(r4[4:0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sumador_completo.md
SUMADOR_COMPLETO -- requirements
Module: sumador_completo

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, operand width in bits (legal range 1..32).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst SHALL be an input, 1 bit: the synchronous, active-high reset.
REQ-005 Port Cin SHALL be an input, 1 bit: the carry in.
REQ-006 Port A SHALL be an input, WIDTH bits: operand A.
REQ-007 Port B SHALL be an input, WIDTH bits: operand B.
REQ-008 Port St SHALL be an output, WIDTH bits: the combinational sum.
REQ-009 Port Cout SHALL be an output, 1 bit: the combinational carry out.
REQ-010 Port St_r SHALL be an output, WIDTH bits: the registered copy of St.
REQ-011 Port Cout_r SHALL be an output, 1 bit: the registered copy of Cout.

Function
REQ-012 {Cout, St} SHALL equal A + B + Cin, computed at WIDTH+1 bits, with no truncation of the carry.
REQ-013 St and Cout SHALL be purely combinational, with zero-cycle latency, and independent of clk and rst.
REQ-014 For WIDTH=1:
- St SHALL equal A xor B xor Cin.
- Cout SHALL equal majority(A, B, Cin).
REQ-015 Carry SHALL ripple from bit 0 to bit WIDTH-1:
- bit 0 receives Cin;
- Cout is the carry out of bit WIDTH-1.
REQ-016 Wrap-around: when A + B + Cin exceeds 2^WIDTH-1, St SHALL hold the low WIDTH bits and Cout SHALL be 1.
REQ-017 On each rising clk edge with rst=0, St_r SHALL load St and Cout_r SHALL load Cout, giving 1-cycle latency.
REQ-018 X/Z on any input MAY propagate to the outputs; no input sanitisation SHALL be performed.
REQ-019 There SHALL be no handshake and no state machine; a new operand is accepted every cycle.

Reset
REQ-020 On a rising clk edge with rst=1, St_r SHALL become 0 and Cout_r SHALL become 0.
REQ-021 rst SHALL NOT affect St or Cout, which track the inputs even while in reset.
REQ-022 If rst asserts mid-stream, the registered outputs SHALL read 0 from the next edge; the first edge after deassertion SHALL load the current sum.
REQ-023 There SHALL be no asynchronous reset path and no reset dependence on power-up values.

Structure
REQ-024 A sub-module sumador_bit (1-bit full adder: inputs a, b, ci; outputs s, co) SHALL be instantiated WIDTH times in a generate loop.
REQ-025 No shared package SHALL be required; the only constant is the WIDTH parameter default of 1.
REQ-026 The output registers SHALL be a single clocked block in sumador_completo and SHALL NOT be placed in sumador_bit.

Verification
REQ-027 WIDTH=1 exhaustive check of all 8 combinations of {Cin, A, B}, each checked 10 time units after being applied:
- 000 -> St=0 Cout=0
- 001 -> St=1 Cout=0
- 010 -> St=1 Cout=0
- 011 -> St=0 Cout=1
- 100 -> St=1 Cout=0
- 101 -> St=0 Cout=1
- 110 -> St=0 Cout=1
- 111 -> St=1 Cout=1
REQ-028 Registered path: rst=0, apply Cin=1, A=1, B=0 -> St_r=0 and Cout_r=1 after exactly one rising edge, and unchanged before that edge.
REQ-029 Reset: hold rst=1 for one edge with A=1, B=1, Cin=1 -> St_r=0 and Cout_r=0, while St=1 and Cout=1 combinationally.
REQ-030 WIDTH=4 wrap-around: A=4'hF, B=4'h1, Cin=0 -> St=4'h0, Cout=1; then A=4'h7, B=4'h8, Cin=1 -> St=4'h0, Cout=1.
REQ-031 WIDTH=4 no-carry case: A=4'h5, B=4'h2, Cin=1 -> St=4'h8, Cout=0; St_r=4'h8 after the next edge.
REQ-032 Reset deassertion: rst falls with inputs A=1, B=1, Cin=0 (WIDTH=1) -> the first edge with rst=0 loads St_r=0, Cout_r=1.
